trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
- Machine-mode trap sequencer between the pipeline and the machine CSR register file.
- On an exception or interrupt, it writes mepc and mcause, updates mstatus, reads mtvec, and issues a PC redirect to the trap handler.
- On MRET, it restores mstatus, reads mepc, and redirects back.
- It drives the CSR file's address, write, read and except-mode inputs, and consumes the CSR file's registered read data.

Parameters:
- VECTORED_EN, 1, when 1 and mtvec[1:0]==01, interrupts go to base+4*code; when 0, every trap uses base.
- CSR_ADDR_W, 32, width of the CSR address bus to the CSR file.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- exc_valid_i  in  1  synchronous exception request; level, held until exc_ack_o.
- exc_cause_i  in  5  exception code.
- exc_pc_i  in  32  PC of the faulting instruction.
- irq_i  in  1  interrupt request, already masked upstream; level, held until exc_ack_o.
- irq_cause_i  in  5  interrupt code.
- mret_i  in  1  MRET request; level, held until exc_ack_o.
- exc_ack_o  out  1  one-cycle pulse; the request is accepted.
- busy_o  out  1  sequencer not idle.
- csr_addr_o  out  CSR_ADDR_W  CSR address.
- csr_we_o  out  1  CSR write enable.
- csr_re_o  out  1  CSR read enable.
- csr_wdata_o  out  32  CSR write data.
- csr_except_o  out  1  except-mode select for the CSR file.
- csr_rdata_i  in  32  CSR read data; valid the cycle after csr_re_o.
- redirect_valid_o  out  1  one-cycle pulse; redirect_pc_o is valid.
- redirect_pc_o  out  32  new fetch PC.

Behaviour:
- CSR addresses:
  - mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342.
  - csr_addr_o is zero-extended to CSR_ADDR_W.
- FSM states: IDLE, T_EPC, T_CAUSE, T_RDST, T_WTST, T_WRST, T_RDTV, T_WTTV, R_RDST, R_WTST, R_WRST, R_RDEP, R_WTEP, DONE.
- csr_* outputs:
  - Moore outputs decoded from the state register only.
  - All zero in IDLE, DONE and every wait state (T_WTST, T_WTTV, R_WTST, R_WTEP).
- Acceptance:
  - Requests are accepted only in IDLE; exc_ack_o is high combinationally in the accepting cycle.
  - Priority when requests coincide: exc_valid_i > mret_i > irq_i.
  - In the accepting cycle, the block latches pc_q = exc_pc_i & ~3, cause_q, and int_q (1 for irq).
  - Requests seen while busy_o is high are ignored; no ack is issued.
- Trap path (cycle 0 = accept):
  - T_EPC: we=1, addr=0x341, wdata=pc_q.
  - T_CAUSE: we=1, addr=0x342, wdata={int_q, 26'b0, cause_q}.
  - T_RDST: re=1, addr=0x300.
  - T_WTST: stat_q <= csr_rdata_i.
  - T_WRST: we=1, addr=0x300, wdata = stat_q with MPIE(7)=stat_q[3], MIE(3)=0, MPP(12:11)=2'b11.
  - T_RDTV: re=1, addr=0x305, except=1.
  - T_WTTV: compute target.
    - base = rdata & ~3.
    - target = base + (cause_q<<2) if VECTORED_EN && rdata[1:0]==01 && int_q; otherwise base.
    - Addition wraps modulo 2^32.
  - DONE (cycle 8): redirect_valid_o=1, redirect_pc_o=target; next state IDLE.
- MRET path:
  - R_RDST: re=1, addr=0x300.
  - R_WTST: capture mstatus.
  - R_WRST: we=1, addr=0x300, wdata with MIE(3)=stat_q[7], MPIE(7)=1, MPP=00.
  - R_RDEP: re=1, addr=0x341, except=1.
  - R_WTEP: target = rdata & ~3.
  - DONE (cycle 6): redirect pulse.
- Other outputs:
  - busy_o = (state != IDLE).
  - redirect_pc_o holds its last value outside DONE.
  - redirect_valid_o is high only in DONE.
- Reset (any time, including mid-sequence):
  - State goes to IDLE immediately.
  - All outputs and internal registers clear to 0.
  - A partially written CSR sequence is abandoned; the requester must re-assert.
- csr_we_o and csr_re_o are never high in the same cycle.

Test Plan:
- Reset then exception: exc_valid_i=1, cause=2, pc=0x0000_1003, mstatus=0x0000_0008, mtvec=0x0000_0100 -> ack at cycle 0; mepc write 0x0000_1000 at cycle 1; mcause write 0x0000_0002 at cycle 2; mstatus write 0x0000_1880 at cycle 5; redirect 0x0000_0100 at cycle 8; busy low at cycle 9.
- Vectored interrupt: irq_i=1, cause=7, mtvec=0x0000_0201 -> mcause write 0x8000_0007; redirect 0x0000_021C.
- Vectored mtvec with an exception (cause=2, mtvec=0x0000_0201) -> redirect 0x0000_0200; with VECTORED_EN=0, the interrupt case also redirects to 0x0000_0200.
- MRET with mstatus=0x0000_1880, mepc=0x0000_1000 -> mstatus write 0x0000_0088 at cycle 3; redirect 0x0000_1000 at cycle 6.
- Simultaneous exc_valid_i, mret_i and irq_i -> exception path taken, one ack; a second exc_valid_i pulse during busy is ignored.
- rst_i asserted at cycle 4 of the trap path -> all outputs 0 in the same cycle, state IDLE, no redirect; a re-asserted request restarts from T_EPC.

Source files
------------

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: saves mepc/mcause, updates mstatus and redirects
// fetch to the mtvec handler on a trap; restores mstatus and returns to mepc on MRET.
module trap_ctrl #(
  parameter bit VECTORED_EN = 1'b1,
  parameter int CSR_ADDR_W  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  exc_valid_i,
  input  logic [4:0]            exc_cause_i,
  input  logic [31:0]           exc_pc_i,
  input  logic                  irq_i,
  input  logic [4:0]            irq_cause_i,
  input  logic                  mret_i,
  output logic                  exc_ack_o,
  output logic                  busy_o,
  output logic [CSR_ADDR_W-1:0] csr_addr_o,
  output logic                  csr_we_o,
  output logic                  csr_re_o,
  output logic [31:0]           csr_wdata_o,
  output logic                  csr_except_o,
  input  logic [31:0]           csr_rdata_i,
  output logic                  redirect_valid_o,
  output logic [31:0]           redirect_pc_o
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  typedef enum logic [3:0] {
    IDLE, T_EPC, T_CAUSE, T_RDST, T_WTST, T_WRST, T_RDTV, T_WTTV,
    R_RDST, R_WTST, R_WRST, R_RDEP, R_WTEP, DONE
  } state_e;

  state_e      r_state;
  state_e      w_next;
  logic [31:0] r_pc;
  logic [4:0]  r_cause;
  logic        r_int;
  logic [31:0] r_stat;
  logic [31:0] r_target;
  logic        w_accept;
  logic [11:0] w_addr;
  logic [31:0] w_base;

  // A request is taken only from IDLE; reset suppresses the ack so every output is quiet during reset
  assign w_accept  = (r_state == IDLE) && !rst_i && (exc_valid_i || mret_i || irq_i);
  assign exc_ack_o = w_accept;
  assign busy_o    = (r_state != IDLE);
  assign w_base    = csr_rdata_i & ~32'd3;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; exception beats MRET beats interrupt when they coincide
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (exc_valid_i)  w_next = T_EPC;
        else if (mret_i)  w_next = R_RDST;
        else if (irq_i)   w_next = T_EPC;
      end
      T_EPC:   w_next = T_CAUSE;
      T_CAUSE: w_next = T_RDST;
      T_RDST:  w_next = T_WTST;
      T_WTST:  w_next = T_WRST;
      T_WRST:  w_next = T_RDTV;
      T_RDTV:  w_next = T_WTTV;
      T_WTTV:  w_next = DONE;
      R_RDST:  w_next = R_WTST;
      R_WTST:  w_next = R_WRST;
      R_WRST:  w_next = R_RDEP;
      R_RDEP:  w_next = R_WTEP;
      R_WTEP:  w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Moore CSR-port outputs, decoded from the state register only
  always_comb begin
    w_addr       = 12'h000;
    csr_we_o     = 1'b0;
    csr_re_o     = 1'b0;
    csr_wdata_o  = 32'h0;
    csr_except_o = 1'b0;
    redirect_valid_o = 1'b0;
    case (r_state)
      T_EPC: begin
        csr_we_o    = 1'b1;
        w_addr      = ADDR_MEPC;
        csr_wdata_o = r_pc;
      end
      T_CAUSE: begin
        csr_we_o    = 1'b1;
        w_addr      = ADDR_MCAUSE;
        csr_wdata_o = {r_int, 26'b0, r_cause};
      end
      T_RDST, R_RDST: begin
        csr_re_o = 1'b1;
        w_addr   = ADDR_MSTATUS;
      end
      T_WRST: begin
        csr_we_o           = 1'b1;
        w_addr             = ADDR_MSTATUS;
        csr_wdata_o        = r_stat;
        csr_wdata_o[7]     = r_stat[3];
        csr_wdata_o[3]     = 1'b0;
        csr_wdata_o[12:11] = 2'b11;
      end
      T_RDTV: begin
        csr_re_o     = 1'b1;
        csr_except_o = 1'b1;
        w_addr       = ADDR_MTVEC;
      end
      R_WRST: begin
        csr_we_o           = 1'b1;
        w_addr             = ADDR_MSTATUS;
        csr_wdata_o        = r_stat;
        csr_wdata_o[3]     = r_stat[7];
        csr_wdata_o[7]     = 1'b1;
        csr_wdata_o[12:11] = 2'b00;
      end
      R_RDEP: begin
        csr_re_o     = 1'b1;
        csr_except_o = 1'b1;
        w_addr       = ADDR_MEPC;
      end
      DONE: redirect_valid_o = 1'b1;
      default: ;
    endcase
  end

  assign csr_addr_o    = CSR_ADDR_W'(w_addr);
  assign redirect_pc_o = r_target;

  // Request capture, mstatus snapshot and redirect-target computation
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc     <= 32'h0;
      r_cause  <= 5'h0;
      r_int    <= 1'b0;
      r_stat   <= 32'h0;
      r_target <= 32'h0;
    end else begin
      if (w_accept) begin
        r_pc <= exc_pc_i & ~32'd3;
        if (exc_valid_i) begin
          r_cause <= exc_cause_i;
          r_int   <= 1'b0;
        end else if (mret_i) begin
          r_cause <= 5'h0;
          r_int   <= 1'b0;
        end else begin
          r_cause <= irq_cause_i;
          r_int   <= 1'b1;
        end
      end
      if (r_state == T_WTST || r_state == R_WTST)
        r_stat <= csr_rdata_i;
      if (r_state == T_WTTV) begin
        if (VECTORED_EN && csr_rdata_i[1:0] == 2'b01 && r_int)
          r_target <= w_base + {25'b0, r_cause, 2'b00};
        else
          r_target <= w_base;
      end
      if (r_state == R_WTEP)
        r_target <= w_base;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: a vectored and a non-vectored instance share
// stimulus, each with a small CSR-file read model driven from bench variables.
module tb_trap_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        exc_valid_i;
   logic [4:0]  exc_cause_i;
   logic [31:0] exc_pc_i;
   logic        irq_i;
   logic [4:0]  irq_cause_i;
   logic        mret_i;

   logic        exc_ack_o, busy_o, csr_we_o, csr_re_o, csr_except_o, redirect_valid_o;
   logic [31:0] csr_addr_o, csr_wdata_o, redirect_pc_o;
   logic [31:0] csr_rdata_i;

   logic        nvAck, nvBusy, nvWe, nvRe, nvExcept, nvRedirValid;
   logic [31:0] nvAddr, nvWdata, nvRedirPc;
   logic [31:0] nvRdata;

   logic [31:0] mstatusVal, mtvecVal, mepcVal;

   int checkCount = 0;
   int passCount  = 0;

   trap_ctrl #(.VECTORED_EN(1'b1), .CSR_ADDR_W(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i), .exc_pc_i(exc_pc_i),
      .irq_i(irq_i), .irq_cause_i(irq_cause_i), .mret_i(mret_i),
      .exc_ack_o(exc_ack_o), .busy_o(busy_o),
      .csr_addr_o(csr_addr_o), .csr_we_o(csr_we_o), .csr_re_o(csr_re_o),
      .csr_wdata_o(csr_wdata_o), .csr_except_o(csr_except_o), .csr_rdata_i(csr_rdata_i),
      .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
   );

   trap_ctrl #(.VECTORED_EN(1'b0), .CSR_ADDR_W(32)) dutNv (
      .clk_i(clk_i), .rst_i(rst_i),
      .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i), .exc_pc_i(exc_pc_i),
      .irq_i(irq_i), .irq_cause_i(irq_cause_i), .mret_i(mret_i),
      .exc_ack_o(nvAck), .busy_o(nvBusy),
      .csr_addr_o(nvAddr), .csr_we_o(nvWe), .csr_re_o(nvRe),
      .csr_wdata_o(nvWdata), .csr_except_o(nvExcept), .csr_rdata_i(nvRdata),
      .redirect_valid_o(nvRedirValid), .redirect_pc_o(nvRedirPc)
   );

   // Free-running clock, 10 time-unit period
   always #5 clk_i = ~clk_i;

   // CSR file read port model: registered data, valid the cycle after a read enable
   always @(posedge clk_i) begin
      if (csr_re_o) begin
         case (csr_addr_o)
            32'h300: csr_rdata_i <= mstatusVal;
            32'h305: csr_rdata_i <= mtvecVal;
            32'h341: csr_rdata_i <= mepcVal;
            default: csr_rdata_i <= 32'h0;
         endcase
      end
      if (nvRe) begin
         case (nvAddr)
            32'h300: nvRdata <= mstatusVal;
            32'h305: nvRdata <= mtvecVal;
            32'h341: nvRdata <= mepcVal;
            default: nvRdata <= 32'h0;
         endcase
      end
   end

   // Advance one cycle and settle just after the active edge
   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   // Drive all request inputs, then let combinational outputs settle
   task automatic applyStimulus(input logic exc, input logic [4:0] excCause, input logic [31:0] pc,
                                input logic irq, input logic [4:0] irqCause, input logic mret);
      exc_valid_i = exc;
      exc_cause_i = excCause;
      exc_pc_i    = pc;
      irq_i       = irq;
      irq_cause_i = irqCause;
      mret_i      = mret;
      #1;
   endtask

   // One comparison: counts it and reports any difference
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
   endtask

   // Runs a trap sequence already accepted in the current cycle to completion
   task automatic runTrap(input string tag, input logic [31:0] expCause,
                          input logic [31:0] expTarget, input logic [31:0] expTargetNv);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
      tick();
      checkOutput({tag, " mcause wdata"}, csr_wdata_o, expCause);
      checkOutput({tag, " mcause addr"}, csr_addr_o, 32'h342);
      repeat (6) tick();
      checkOutput({tag, " redirect valid"}, {31'b0, redirect_valid_o}, 32'd1);
      checkOutput({tag, " redirect pc"}, redirect_pc_o, expTarget);
      checkOutput({tag, " nonvectored pc"}, nvRedirPc, expTargetNv);
      tick();
      checkOutput({tag, " busy after"}, {31'b0, busy_o}, 32'd0);
   endtask

   initial begin
      mstatusVal  = 32'h0;
      mtvecVal    = 32'h0;
      mepcVal     = 32'h0;
      csr_rdata_i = 32'h0;
      nvRdata     = 32'h0;
      rst_i = 1'b1;
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
      tick();
      tick();
      checkOutput("reset busy", {31'b0, busy_o}, 32'd0);
      checkOutput("reset csr_we/re/except", {29'b0, csr_we_o, csr_re_o, csr_except_o}, 32'd0);
      checkOutput("reset redirect pc", redirect_pc_o, 32'h0);
      rst_i = 1'b0;
      tick();

      $display("[TB] exception trap, direct mtvec");
      mstatusVal = 32'h0000_0008;
      mtvecVal   = 32'h0000_0100;
      applyStimulus(1'b1, 5'd2, 32'h0000_1003, 1'b0, 5'd0, 1'b0);
      checkOutput("t1 ack c0", {31'b0, exc_ack_o}, 32'd1);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
      checkOutput("t1 ack c1", {31'b0, exc_ack_o}, 32'd0);
      checkOutput("t1 busy c1", {31'b0, busy_o}, 32'd1);
      checkOutput("t1 mepc we", {31'b0, csr_we_o}, 32'd1);
      checkOutput("t1 mepc addr", csr_addr_o, 32'h341);
      checkOutput("t1 mepc wdata", csr_wdata_o, 32'h0000_1000);
      tick();
      checkOutput("t1 mcause addr", csr_addr_o, 32'h342);
      checkOutput("t1 mcause wdata", csr_wdata_o, 32'h0000_0002);
      tick();
      checkOutput("t1 rdst we/re", {30'b0, csr_we_o, csr_re_o}, 32'd1);
      checkOutput("t1 rdst addr", csr_addr_o, 32'h300);
      tick();
      checkOutput("t1 wait quiet", {29'b0, csr_we_o, csr_re_o, csr_except_o}, 32'd0);
      checkOutput("t1 wait addr", csr_addr_o, 32'h0);
      tick();
      checkOutput("t1 mstatus we", {31'b0, csr_we_o}, 32'd1);
      checkOutput("t1 mstatus wdata", csr_wdata_o, 32'h0000_1880);
      tick();
      checkOutput("t1 mtvec re/except", {30'b0, csr_re_o, csr_except_o}, 32'd3);
      checkOutput("t1 mtvec addr", csr_addr_o, 32'h305);
      tick();
      checkOutput("t1 redirect c7", {31'b0, redirect_valid_o}, 32'd0);
      tick();
      checkOutput("t1 redirect valid c8", {31'b0, redirect_valid_o}, 32'd1);
      checkOutput("t1 redirect pc", redirect_pc_o, 32'h0000_0100);
      tick();
      checkOutput("t1 busy c9", {31'b0, busy_o}, 32'd0);
      checkOutput("t1 redirect valid c9", {31'b0, redirect_valid_o}, 32'd0);
      checkOutput("t1 redirect pc hold", redirect_pc_o, 32'h0000_0100);

      $display("[TB] vectored interrupt");
      mtvecVal = 32'h0000_0201;
      applyStimulus(1'b0, 5'd0, 32'h0000_3000, 1'b1, 5'd7, 1'b0);
      checkOutput("t2 ack", {31'b0, exc_ack_o}, 32'd1);
      runTrap("t2", 32'h8000_0007, 32'h0000_021C, 32'h0000_0200);

      $display("[TB] exception with vectored mtvec");
      applyStimulus(1'b1, 5'd2, 32'h0000_4004, 1'b0, 5'd0, 1'b0);
      runTrap("t3", 32'h0000_0002, 32'h0000_0200, 32'h0000_0200);

      $display("[TB] mret");
      mstatusVal = 32'h0000_1880;
      mepcVal    = 32'h0000_1000;
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
      checkOutput("t4 ack", {31'b0, exc_ack_o}, 32'd1);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
      checkOutput("t4 rdst addr", csr_addr_o, 32'h300);
      checkOutput("t4 rdst re", {31'b0, csr_re_o}, 32'd1);
      tick();
      tick();
      checkOutput("t4 mstatus we", {31'b0, csr_we_o}, 32'd1);
      checkOutput("t4 mstatus wdata", csr_wdata_o, 32'h0000_0088);
      tick();
      checkOutput("t4 mepc read", {csr_addr_o[29:0], csr_re_o, csr_except_o}, {30'h341, 2'b11});
      tick();
      tick();
      checkOutput("t4 redirect valid c6", {31'b0, redirect_valid_o}, 32'd1);
      checkOutput("t4 redirect pc", redirect_pc_o, 32'h0000_1000);
      tick();
      checkOutput("t4 busy c7", {31'b0, busy_o}, 32'd0);

      $display("[TB] simultaneous requests and request during busy");
      mtvecVal = 32'h0000_0100;
      mstatusVal = 32'h0000_0008;
      applyStimulus(1'b1, 5'd3, 32'h0000_5000, 1'b1, 5'd5, 1'b1);
      checkOutput("t5 ack", {31'b0, exc_ack_o}, 32'd1);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
      checkOutput("t5 mepc wdata", csr_wdata_o, 32'h0000_5000);
      tick();
      checkOutput("t5 mcause wdata", csr_wdata_o, 32'h0000_0003);
      applyStimulus(1'b1, 5'd9, 32'h0000_6000, 1'b0, 5'd0, 1'b0);
      checkOutput("t5 ack while busy", {31'b0, exc_ack_o}, 32'd0);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
      repeat (5) tick();
      checkOutput("t5 redirect pc", {redirect_pc_o[30:0], redirect_valid_o}, {31'h0000_0100, 1'b1});
      tick();
      checkOutput("t5 idle after", {31'b0, busy_o}, 32'd0);

      $display("[TB] reset mid-sequence");
      applyStimulus(1'b1, 5'd4, 32'h0000_7000, 1'b0, 5'd0, 1'b0);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
      repeat (3) tick();
      rst_i = 1'b1;
      #1;
      checkOutput("t6 busy in reset", {31'b0, busy_o}, 32'd0);
      checkOutput("t6 csr quiet in reset", {29'b0, csr_we_o, csr_re_o, csr_except_o}, 32'd0);
      checkOutput("t6 wdata in reset", csr_wdata_o, 32'h0);
      checkOutput("t6 redirect pc in reset", redirect_pc_o, 32'h0);
      checkOutput("t6 redirect valid in reset", {31'b0, redirect_valid_o}, 32'd0);
      tick();
      rst_i = 1'b0;
      tick();
      applyStimulus(1'b1, 5'd1, 32'h0000_2002, 1'b0, 5'd0, 1'b0);
      checkOutput("t6 reack", {31'b0, exc_ack_o}, 32'd1);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
      checkOutput("t6 restart mepc addr", csr_addr_o, 32'h341);
      checkOutput("t6 restart mepc wdata", csr_wdata_o, 32'h0000_2000);
      repeat (8) tick();
      checkOutput("t6 restart done idle", {31'b0, busy_o}, 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
